// File: rtl/decode_stage_if.sv
// Bundles the decode-stage D-side inputs, write-back port and registered E-side outputs.
// The master drives instruction/PC/write-back/flush; the slave (decode stage) returns ID/EX data.
interface decode_stage_if #(
  parameter int unsigned WIDTH = 32
);
  // D-side inputs from the IF/ID register
  logic [WIDTH-1:0] instrD;
  logic [WIDTH-1:0] pcD;
  logic [WIDTH-1:0] pcplus4D;

  // Write-back port
  logic             regwriteW;
  logic [4:0]       rdW;
  logic [WIDTH-1:0] resultW;

  logic             flushE;

  // ID/EX register outputs
  logic [WIDTH-1:0] rd1E;
  logic [WIDTH-1:0] rd2E;
  logic [WIDTH-1:0] immextE;
  logic [WIDTH-1:0] pcE;
  logic [WIDTH-1:0] pcplus4E;
  logic [4:0]       rs1E;
  logic [4:0]       rs2E;
  logic [4:0]       rdE;
  logic             regwriteE;
  logic             memwriteE;
  logic             jumpE;
  logic             branchE;
  logic             alusrcE;
  logic [1:0]       resultsrcE;
  logic [3:0]       alucontrolE;
  logic [2:0]       funct3E;

  logic [WIDTH-1:0] a0_out;

  modport master (
    output instrD, pcD, pcplus4D, regwriteW, rdW, resultW, flushE,
    input  rd1E, rd2E, immextE, pcE, pcplus4E, rs1E, rs2E, rdE,
    input  regwriteE, memwriteE, jumpE, branchE, alusrcE,
    input  resultsrcE, alucontrolE, funct3E, a0_out
  );

  modport slave (
    input  instrD, pcD, pcplus4D, regwriteW, rdW, resultW, flushE,
    output rd1E, rd2E, immextE, pcE, pcplus4E, rs1E, rs2E, rdE,
    output regwriteE, memwriteE, jumpE, branchE, alusrcE,
    output resultsrcE, alucontrolE, funct3E, a0_out
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-through, immediate generation, main/ALU
// decoders and the ID/EX pipeline register with flush; x10 is exported as a0_out.
module decode_stage #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpAluImm = 7'b0010011,
    OpStore  = 7'b0100011,
    OpAluReg = 7'b0110011,
    OpLui    = 7'b0110111,
    OpBranch = 7'b1100011,
    OpJalr   = 7'b1100111,
    OpJal    = 7'b1101111
  } opcode_e;

  typedef enum logic [3:0] {
    AluAdd   = 4'b0000,
    AluSub   = 4'b0001,
    AluAnd   = 4'b0010,
    AluOr    = 4'b0011,
    AluXor   = 4'b0100,
    AluSll   = 4'b0101,
    AluSrl   = 4'b0110,
    AluSra   = 4'b0111,
    AluSlt   = 4'b1000,
    AluSltu  = 4'b1001,
    AluPassB = 4'b1010
  } alu_op_e;

  logic [WIDTH-1:0] rf_q [32];

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = bus.instrD[6:0];
  assign rd        = bus.instrD[11:7];
  assign funct3    = bus.instrD[14:12];
  assign rs1       = bus.instrD[19:15];
  assign rs2       = bus.instrD[24:20];
  assign funct7_b5 = bus.instrD[30];

  // Register file: x0 is never written, so it reads 0 after reset.
  logic wb_en;
  assign wb_en = bus.regwriteW && (bus.rdW != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en) begin
      rf_q[bus.rdW] <= bus.resultW;
    end
  end

  // Same-cycle write-back forwards into the read ports.
  logic [WIDTH-1:0] rd1, rd2;

  always_comb begin
    rd1 = rf_q[rs1];
    rd2 = rf_q[rs2];
    if (rs1 == 5'd0) begin
      rd1 = '0;
    end else if (wb_en && (bus.rdW == rs1)) begin
      rd1 = bus.resultW;
    end
    if (rs2 == 5'd0) begin
      rd2 = '0;
    end else if (wb_en && (bus.rdW == rs2)) begin
      rd2 = bus.resultW;
    end
  end

  assign bus.a0_out = rf_q[10];

  // Immediate generation: built as a signed 32-bit value, then sign-extended to WIDTH.
  logic signed [31:0] imm32;
  logic [WIDTH-1:0]   immext;

  always_comb begin
    imm32 = '0;
    case (opcode)
      OpLoad, OpAluImm, OpJalr: begin
        imm32 = {{20{bus.instrD[31]}}, bus.instrD[31:20]};
      end
      OpStore: begin
        imm32 = {{20{bus.instrD[31]}}, bus.instrD[31:25], bus.instrD[11:7]};
      end
      OpBranch: begin
        imm32 = {{19{bus.instrD[31]}}, bus.instrD[31], bus.instrD[7], bus.instrD[30:25],
                 bus.instrD[11:8], 1'b0};
      end
      OpJal: begin
        imm32 = {{11{bus.instrD[31]}}, bus.instrD[31], bus.instrD[19:12], bus.instrD[20],
                 bus.instrD[30:21], 1'b0};
      end
      OpLui: begin
        imm32 = {bus.instrD[31:12], 12'b0};
      end
      default: imm32 = '0;
    endcase
  end

  assign immext = WIDTH'(imm32);

  // Shared funct3 decode for register and immediate ALU ops; sub exists only for R-type.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic f7b5,
                                             input logic is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = f7b5 ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic       regwrite, memwrite, jump, branch, alusrc;
  logic [1:0] resultsrc;
  alu_op_e    alucontrol;

  always_comb begin
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alusrc     = 1'b0;
    resultsrc  = 2'b00;
    alucontrol = AluAdd;
    case (opcode)
      OpAluReg: begin
        regwrite   = 1'b1;
        alucontrol = alu_from_funct(funct3, funct7_b5, 1'b1);
      end
      OpAluImm: begin
        regwrite   = 1'b1;
        alusrc     = 1'b1;
        alucontrol = alu_from_funct(funct3, funct7_b5, 1'b0);
      end
      OpLoad: begin
        regwrite  = 1'b1;
        alusrc    = 1'b1;
        resultsrc = 2'b01;
      end
      OpStore: begin
        memwrite = 1'b1;
        alusrc   = 1'b1;
      end
      OpBranch: begin
        branch     = 1'b1;
        alucontrol = AluSub;
      end
      OpJal: begin
        jump      = 1'b1;
        regwrite  = 1'b1;
        resultsrc = 2'b10;
      end
      OpJalr: begin
        jump      = 1'b1;
        regwrite  = 1'b1;
        alusrc    = 1'b1;
        resultsrc = 2'b10;
      end
      OpLui: begin
        regwrite   = 1'b1;
        alusrc     = 1'b1;
        alucontrol = AluPassB;
      end
      default: ;
    endcase
  end

  // ID/EX register: reset and flush both produce an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || bus.flushE) begin
      bus.rd1E        <= '0;
      bus.rd2E        <= '0;
      bus.immextE     <= '0;
      bus.pcE         <= '0;
      bus.pcplus4E    <= '0;
      bus.rs1E        <= '0;
      bus.rs2E        <= '0;
      bus.rdE         <= '0;
      bus.regwriteE   <= 1'b0;
      bus.memwriteE   <= 1'b0;
      bus.jumpE       <= 1'b0;
      bus.branchE     <= 1'b0;
      bus.alusrcE     <= 1'b0;
      bus.resultsrcE  <= '0;
      bus.alucontrolE <= '0;
      bus.funct3E     <= '0;
    end else begin
      bus.rd1E        <= rd1;
      bus.rd2E        <= rd2;
      bus.immextE     <= immext;
      bus.pcE         <= bus.pcD;
      bus.pcplus4E    <= bus.pcplus4D;
      bus.rs1E        <= rs1;
      bus.rs2E        <= rs2;
      bus.rdE         <= rd;
      bus.regwriteE   <= regwrite;
      bus.memwriteE   <= memwrite;
      bus.jumpE       <= jump;
      bus.branchE     <= branch;
      bus.alusrcE     <= alusrc;
      bus.resultsrcE  <= resultsrc;
      bus.alucontrolE <= alucontrol;
      bus.funct3E     <= funct3;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a register-file model plus hand-decoded controls feed a
// scoreboard queue that is checked one cycle after each instruction is presented.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  decode_stage_if #(.WIDTH(32)) bus ();

  decode_stage #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ctrl packing: {regwrite, memwrite, jump, branch, alusrc, resultsrc[1:0], alucontrol[3:0]}
  localparam logic [10:0] CAdd   = 11'b1_0_0_0_0_00_0000;
  localparam logic [10:0] CAddi  = 11'b1_0_0_0_1_00_0000;
  localparam logic [10:0] CSw    = 11'b0_1_0_0_1_00_0000;
  localparam logic [10:0] CSub   = 11'b1_0_0_0_0_00_0001;
  localparam logic [10:0] CSra   = 11'b1_0_0_0_0_00_0111;
  localparam logic [10:0] CSrai  = 11'b1_0_0_0_1_00_0111;
  localparam logic [10:0] CSlt   = 11'b1_0_0_0_0_00_1000;
  localparam logic [10:0] CLui   = 11'b1_0_0_0_1_00_1010;
  localparam logic [10:0] CBeq   = 11'b0_0_0_1_0_00_0001;
  localparam logic [10:0] CJal   = 11'b1_0_1_0_0_10_0000;
  localparam logic [10:0] CNone  = 11'b0;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [14:0] regs;
    logic [10:0] ctrl;
    logic [2:0]  f3;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] m_rf [32];
  logic [31:0] pc_cnt = 32'h0000_1000;
  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL step %0d %s observed %h expected %h", step_no, tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] instr, input logic rst_v, input logic flush_v,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
                      input logic [10:0] ctrl, input logic [31:0] imm);
    exp_t        e;
    exp_t        o;
    logic [4:0]  rs1, rs2;
    logic [31:0] pc;
    step_no++;
    pc            = pc_cnt;
    pc_cnt        = pc_cnt + 32'd4;
    rs1           = instr[19:15];
    rs2           = instr[24:20];
    rst           = rst_v;
    bus.instrD    = instr;
    bus.pcD       = pc;
    bus.pcplus4D  = pc + 32'd4;
    bus.flushE    = flush_v;
    bus.regwriteW = we;
    bus.rdW       = wrd;
    bus.resultW   = wdata;

    e = '0;
    if (!rst_v && !flush_v) begin
      e.rd1  = (we && wrd != 0 && wrd == rs1) ? wdata : m_rf[rs1];
      e.rd2  = (we && wrd != 0 && wrd == rs2) ? wdata : m_rf[rs2];
      e.imm  = imm;
      e.pc   = pc;
      e.pcp4 = pc + 32'd4;
      e.regs = {rs1, rs2, instr[11:7]};
      e.ctrl = ctrl;
      e.f3   = instr[14:12];
    end
    sb_q.push_back(e);

    @(posedge clk);
    if (rst_v) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else if (we && wrd != 0) begin
      m_rf[wrd] = wdata;
    end
    #1;

    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      o.rd1  = bus.rd1E;
      o.rd2  = bus.rd2E;
      o.imm  = bus.immextE;
      o.pc   = bus.pcE;
      o.pcp4 = bus.pcplus4E;
      o.regs = {bus.rs1E, bus.rs2E, bus.rdE};
      o.ctrl = {bus.regwriteE, bus.memwriteE, bus.jumpE, bus.branchE, bus.alusrcE,
                bus.resultsrcE, bus.alucontrolE};
      o.f3   = bus.funct3E;
      chk("rd1E", o.rd1, e.rd1);
      chk("rd2E", o.rd2, e.rd2);
      chk("immextE", o.imm, e.imm);
      chk("pcE", o.pc, e.pc);
      chk("pcplus4E", o.pcp4, e.pcp4);
      chk("rs1E_rs2E_rdE", 32'(o.regs), 32'(e.regs));
      chk("controls", 32'(o.ctrl), 32'(e.ctrl));
      chk("funct3E", 32'(o.f3), 32'(e.f3));
    end
    chk("a0_out", bus.a0_out, m_rf[10]);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    bus.instrD    = '0;
    bus.pcD       = '0;
    bus.pcplus4D  = '0;
    bus.flushE    = 1'b0;
    bus.regwriteW = 1'b0;
    bus.rdW       = '0;
    bus.resultW   = '0;

    // Reset beats a concurrent write to x5
    step(32'h0001_8233, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_DEAD, CNone, 32'h0);
    // add x1,x5,x0: x5 must read 0
    step(32'h0002_80B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, CAdd, 32'h0);
    // Write-through: x3 <= 0x1234 while decoding add x4,x3,x0
    step(32'h0001_8233, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_1234, CAdd, 32'h0);
    // Write to x0 ignored; addi x1,x0,-1
    step(32'hFFF0_0093, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, CAddi, 32'hFFFF_FFFF);
    // add x1,x0,x0 reads 0; write x1 <= 0x10
    step(32'h0000_00B3, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0000_0010, CAdd, 32'h0);
    // sub x5,x1,x2 with x2 forwarded
    step(32'h4020_82B3, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0003, CSub, 32'h0);
    // sra x6,x1,x2; write a0
    step(32'h4020_D333, 1'b0, 1'b0, 1'b1, 5'd10, 32'hCAFE_BABE, CSra, 32'h0);
    // srai x7,x1,3
    step(32'h4030_D393, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, CSrai, 32'h0000_0403);
    // slt x8,x1,x2
    step(32'h0020_A433, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, CSlt, 32'h0);
    // Flushed sw: bubble, but the x3 write still lands
    step(32'h0020_A423, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0055, CSw, 32'h0000_0008);
    // Same sw unflushed
    step(32'h0020_A423, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, CSw, 32'h0000_0008);
    // lui x9,0x12345
    step(32'h1234_54B7, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, CLui, 32'h1234_5000);
    // beq x1,x2,-4
    step(32'hFE20_8EE3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, CBeq, 32'hFFFF_FFFC);
    // jal x1,8
    step(32'h0080_00EF, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, CJal, 32'h0000_0008);
    // Illegal opcode: controls zero, data still registered
    step(32'h0000_007F, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, CNone, 32'h0);
    // Mid-operation reset with a pending write to x6
    step(32'h4020_82B3, 1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_0077, CNone, 32'h0);
    // add x11,x10,x3: both cleared by reset
    step(32'h0035_05B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, CAdd, 32'h0);
    // add x1,x6,x0: discarded write left x6 at 0
    step(32'h0003_00B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, CAdd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, the datapath and register width.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port instrD, input, WIDTH, the instruction from the IF/ID register.
REQ-005 The block SHALL have ports pcD and pcplus4D, input, WIDTH each, the PC and PC+4 from the IF/ID register.
REQ-006 The block SHALL have ports regwriteW (1), rdW (5) and resultW (WIDTH), all inputs, the write-back port.
REQ-007 The block SHALL have port flushE, input, 1, which inserts a bubble into the ID/EX register.
REQ-008 The block SHALL have ports rd1E, rd2E, immextE, pcE and pcplus4E, output, WIDTH each, the ID/EX data.
REQ-009 The block SHALL have ports rs1E, rs2E and rdE, output, 5 each, the register indices for hazard detection.
REQ-010 The block SHALL have ports regwriteE, memwriteE, jumpE, branchE and alusrcE, output, 1 each, the ID/EX control bits.
REQ-011 The block SHALL have ports resultsrcE (2), alucontrolE (4) and funct3E (3), all outputs.
REQ-012 The block SHALL have port a0_out, output, WIDTH, the live contents of x10.

Function
REQ-013 The block SHALL contain a 32 x WIDTH register file with two combinational read ports (rs1 = instrD[19:15], rs2 = instrD[24:20]).
REQ-014 The register file SHALL be written on the rising edge of clk when regwriteW=1 and rdW!=0; writes to x0 SHALL be ignored, and x0 SHALL always read 0.
REQ-015 When regwriteW=1, rdW!=0 and rdW equals a read index in the same cycle, that read SHALL return resultW (write-through).
REQ-016 The immediate SHALL be sign-extended per format: I for opcodes 0000011, 0010011 and 1100111; S for 0100011; B for 1100011, with bit0=0; J for 1101111, with bit0=0; U for 0110111, as {instr[31:12], 12'b0}.
REQ-017 The main decoder SHALL produce controls per opcode:
- R 0110011: regwrite=1, alusrc=0, resultsrc=00.
- I-ALU 0010011: regwrite=1, alusrc=1, resultsrc=00.
- lw 0000011: regwrite=1, alusrc=1, resultsrc=01.
- sw 0100011: memwrite=1, alusrc=1.
- branch 1100011: branch=1, alusrc=0, alu=sub.
- jal 1101111: jump=1, regwrite=1, resultsrc=10.
- jalr 1100111: jump=1, regwrite=1, alusrc=1, resultsrc=10.
- lui 0110111: regwrite=1, alusrc=1, alu=passB.
REQ-018 alucontrol encoding SHALL be: add 0000, sub 0001, and 0010, or 0011, xor 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001, passB 1010.
REQ-019 ALU select SHALL come from funct3/funct7[5]:
- sub only when R-type and funct7[5]=1.
- sra when funct3=101 and funct7[5]=1, for both R-type and I-type.
- lw, sw, jal and jalr SHALL use add.
REQ-020 Any unlisted opcode SHALL decode to all control bits 0 (a bubble); data fields SHALL still be registered.
REQ-021 All E outputs SHALL be registered: one-cycle latency from the D inputs to the E outputs.
REQ-022 funct3E SHALL carry instrD[14:12]; rdE SHALL carry instrD[11:7].
REQ-023 When flushE=1 at a clock edge, all E outputs SHALL become 0 in the next cycle; flush SHALL not affect register-file writes.
REQ-024 a0_out SHALL be the registered x10 value, and SHALL reflect a write to x10 in the cycle after the write edge.

Reset
REQ-025 When rst=1 at a rising edge, all E outputs and all 32 registers SHALL be set to 0, and a0_out SHALL be 0.
REQ-026 rst SHALL take priority over flushE and regwriteW in the same cycle.
REQ-027 When rst is asserted mid-operation, the instruction in flight SHALL be discarded, with no register written.

Verification
REQ-028 Reset: rst=1 for one cycle with regwriteW=1, rdW=5 -> all outputs 0, and x5 reads 0 afterwards.
REQ-029 Write-through: regwriteW=1, rdW=3, resultW=0x1234, with instrD=add x4,x3,x0 in the same cycle -> rd1E=0x00001234 next cycle.
REQ-030 x0 protection: write rdW=0, resultW=0xFFFFFFFF, then decode add x1,x0,x0 -> rd1E=0.
REQ-031 Immediate: instrD=0xFFF00093 (addi x1,x0,-1) -> immextE=0xFFFFFFFF, alusrcE=1, regwriteE=1, alucontrolE=0000.
REQ-032 Flush: valid sw in D with flushE=1 -> next cycle memwriteE=0 and all E outputs 0; the following unflushed instruction decodes normally.
REQ-033 Decoder sweep: sub, sra/srai, slt, lui 0x12345, beq, jal and an illegal opcode 0x0000007F -> alucontrolE and controls per REQ-017 to REQ-020, e.g. lui gives immextE=0x12345000 and alucontrolE=1010.
